// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory arbiter slice.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_WIDTH   = 16;
  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the search starts one past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    int cand;
    cand  = 0;
    any   = 1'b0;
    index = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!any && valid[cand]) begin
        any   = 1'b1;
        index = IDX_W'(cand);
      end
    end
    grant = any ? (NUM_REQ'(1) << index) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous memory among requesters.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a WAIT-state timeout with rsp_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_valid,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic                          mem_ready,
  input  logic [WIDTH-1:0]              mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid (req_valid),
    .last  (last_grant),
    .grant (grant),
    .index (grant_idx),
    .any   (grant_any)
  );

  // Gated by reset so the grant cannot leak out while the block is held in reset.
  assign req_ready = (reset && state == IDLE) ? grant : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      mem_valid  <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      mem_valid <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_idx;
            last_grant <= grant_idx;
            mem_wr     <= req_wr[grant_idx];
            mem_addr   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata  <= req_wdata[grant_idx*WIDTH +: WIDTH];
            mem_valid  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          // A real memory answer takes priority over a timeout in the same cycle.
          if (mem_ready) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_rdata <= mem_wr ? '0 : mem_rdata;
            state     <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            rsp_err_q <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt  <= wait_cnt + 1'b1;
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_rdata <= '0;
            rsp_err_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares one single-port synchronous memory (valid/WR/addr/data_in in, data_out/ready out, ready and read data registered one cycle after valid) between NUM_REQ requesters. It accepts one request at a time over a per-requester valid/ready handshake, issues a single-cycle memory access, captures the memory's ready/data_out, and returns a one-cycle response pulse to the granted requester. It sits directly in front of the memory; requesters never drive the memory ports.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, at least 2.
- DEPTH, 1024: memory depth, matching the attached memory.
- WIDTH, 16: data width.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- TIMEOUT, 15: wait-cycle limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  Clock; rising edge.
- reset  in  1  Asynchronous, active-low reset.
- req_valid  in  NUM_REQ  Per-requester request valid.
- req_ready  out  NUM_REQ  One-hot grant; a handshake completes when req_valid[i] and req_ready[i] are both 1.
- req_wr  in  NUM_REQ  Per-requester write flag: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  Packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*WIDTH  Packed write data.
- rsp_valid  out  NUM_REQ  One-cycle completion pulse to the owning requester.
- rsp_rdata  out  WIDTH  Read data; valid while any rsp_valid bit is 1.
- rsp_err  out  1  Timeout flag, qualified by rsp_valid.
- mem_valid, mem_wr  out  1 each  To memory valid and WR.
- mem_addr  out  ADDR_WIDTH  To memory addr.
- mem_wdata  out  WIDTH  To memory data_in.
- mem_ready  in  1  From memory ready.
- mem_rdata  in  WIDTH  From memory data_out.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - req_ready is the combinational round-robin grant over req_valid. The search starts at last_grant+1 mod NUM_REQ.
  - On a handshake, latch the owner index, wr, addr and wdata; set last_grant to the owner; go to ISSUE.
  - With no req_valid set, req_ready stays 0.
- ISSUE: assert mem_valid=1 for exactly one cycle, with mem_wr, mem_addr and mem_wdata taken from the latches; go to WAIT. req_ready is 0.
- WAIT: req_ready is 0. When mem_ready=1, register rsp_valid[owner]=1 and rsp_err=0.
  - Read: rsp_rdata is set to mem_rdata.
  - Write: rsp_rdata is set to 0.
  - Then go to IDLE.
- rsp_valid is a single-cycle pulse. rsp_rdata holds its value until the next response.
- Outside ISSUE, mem_valid=0. mem_wr, mem_addr and mem_wdata hold their last latched values.
- Requesters keep req_valid and their fields stable until the handshake completes. The arbiter does not check this.
- mem_ready arriving outside WAIT is ignored.
- Reset while asserted (low):
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first).
  - All outputs are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_wr, mem_addr, mem_wdata.
  - A transaction in flight is dropped with no response. A write that already reached the memory may still have taken effect.

## Timing
- Cycle 0: handshake.
- Cycle 1: mem_valid high.
- Cycle 2: memory ready observed.
- Cycle 3: rsp_valid high. IDLE can accept the next handshake in this same cycle.
- Latency from handshake to rsp_valid is 3 cycles. Throughput is one access per 3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Each requester with req_valid held continuously is served within NUM_REQ transactions.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An up-counter with $clog2(TIMEOUT+1) bits clears on entry to WAIT and increments each WAIT cycle that has no mem_ready.
  - If it reaches TIMEOUT, register rsp_valid[owner]=1, rsp_err=1 and rsp_rdata=0, then go to IDLE.
  - If mem_ready arrives in the same cycle the count reaches TIMEOUT, mem_ready wins and the response is a normal one.
- MEM_ARB_TIMEOUT_EN undefined: WAIT lasts indefinitely, rsp_err is tied to 0, and no counter is present.

## Structure
- Package mem_arb_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT);
  - default widths for DEPTH, WIDTH and NUM_REQ;
  - the state encoding width.
- Sub-module rr_arbiter: combinational grant from req_valid and last_grant, with one-hot grant and binary index outputs. It is parameterized by NUM_REQ and reused for any future requester-sharing blocks.

## Test plan
- Reset low mid-WAIT, then release: all outputs are 0, no rsp_valid pulse is produced, and the next request is granted in IDLE normally.
- Requester 1 writes 16'hBEEF to addr 10, then requester 2 reads addr 10:
  - write: rsp_valid[1] 3 cycles after its handshake, with rsp_rdata=0;
  - read: rsp_valid[2] with rsp_rdata=16'hBEEF.
- All 4 requesters hold req_valid from reset release: grant order is 0,1,2,3,0, with handshakes 3 cycles apart.
- Requester 3 drops req_valid after being served once while requesters 0 and 3 otherwise stay active: grants alternate fairly, and requester 3 waits at most NUM_REQ transactions once it re-requests.
- MEM_ARB_TIMEOUT_EN with mem_ready forced to 0:
  - rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, TIMEOUT+1 cycles after mem_valid;
  - the FSM returns to IDLE;
  - a late mem_ready pulse is ignored.
- A mem_ready pulse injected while in IDLE: no rsp_valid is produced and no state change occurs.
